// File: rtl/cnn_mem_ctrl.sv
// CNN memory controller: CPU word read/write port plus byte-stream bulk loader
// in front of a single 16-bit word array.
module cnn_mem_ctrl #(
   parameter int READ_LAT = 2,
   parameter int DEPTH    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [11:0] address,
   input  logic [15:0] to_memory,
   output logic [15:0] from_memory,
   output logic        mem_ready,
   input  logic        ld_en,
   input  logic        ld_valid,
   input  logic [7:0]  ld_data,
   output logic        ld_ready,
   output logic        ld_done
);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DONE,
      WR_DONE,
      LOAD
   } state_t;

   localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic [11:0] r_rd_addr;
   logic [11:0] r_ld_addr;
   logic        r_phase;
   logic [7:0]  r_lo;
   logic [15:0] r_rdata;
   logic        r_ld_done;
   logic [15:0] r_mem [DEPTH];

   logic        w_we;
   logic [11:0] w_waddr;
   logic [15:0] w_wdata;
   logic        w_start_rd;
   logic        w_start_ld;
   logic        w_rd_load;
   logic        w_ld_take;
   logic        w_ld_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_we       = 1'b0;
      w_waddr    = address;
      w_wdata    = to_memory;
      w_start_rd = 1'b0;
      w_start_ld = 1'b0;
      w_rd_load  = 1'b0;
      w_ld_take  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (wr_req) begin
               w_we   = 1'b1;
               w_next = WR_DONE;
            end else if (rd_req) begin
               w_start_rd = 1'b1;
               w_next     = RD_WAIT;
            end else if (ld_en) begin
               w_start_ld = 1'b1;
               w_next     = LOAD;
            end
         end
         // counter runs 0..READ_LAT: one accept cycle plus READ_LAT waits
         RD_WAIT: begin
            if (r_cnt == 3'(READ_LAT)) begin
               w_rd_load = 1'b1;
               w_next    = RD_DONE;
            end
         end
         RD_DONE: w_next = IDLE;
         WR_DONE: w_next = IDLE;
         LOAD: begin
            w_ld_take = ld_valid;
            if (ld_valid && r_phase) begin
               w_we    = 1'b1;
               w_waddr = r_ld_addr;
               w_wdata = {ld_data, r_lo};
            end
            if (!ld_en) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_ld_last = w_ld_take && r_phase &&
                      (r_ld_addr == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 3'd0;
         r_rd_addr <= 12'd0;
         r_ld_addr <= 12'd0;
         r_phase   <= 1'b0;
         r_lo      <= 8'd0;
         r_rdata   <= 16'h0000;
         r_ld_done <= 1'b0;
      end else begin
         r_ld_done <= w_ld_last;
         if (w_start_rd) begin
            r_rd_addr <= address;
            r_cnt     <= 3'd0;
         end else if (r_state == RD_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_rd_load) r_rdata <= r_mem[r_rd_addr];
         if (w_start_ld) begin
            r_ld_addr <= 12'd0;
            r_phase   <= 1'b0;
         end else if (w_ld_take) begin
            r_phase <= ~r_phase;
            if (!r_phase)      r_lo      <= ld_data;
            else if (w_ld_last) r_ld_addr <= 12'd0;
            else               r_ld_addr <= r_ld_addr + 12'd1;
         end
      end
   end

   assign from_memory = r_rdata;
   assign mem_ready   = (r_state == RD_DONE) || (r_state == WR_DONE);
   assign ld_ready    = (r_state == LOAD);
   assign ld_done     = r_ld_done;

endmodule

// File: tb/tb_cnn_mem_ctrl.sv
// Scoreboard bench for cnn_mem_ctrl: drivers queue expected completions,
// a negedge monitor checks every mem_ready and ld_done pulse.
module tb_cnn_mem_ctrl;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_req = 1'b0;
   logic        wr_req = 1'b0;
   logic [11:0] address = 12'd0;
   logic [15:0] to_memory = 16'd0;
   logic [15:0] from_memory;
   logic        mem_ready;
   logic        ld_en = 1'b0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_data = 8'd0;
   logic        ld_ready;
   logic        ld_done;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          ld_done_exp = -1;
   int          ld_done_cnt = 0;
   logic [15:0] exp_fm = 16'h0000;

   cnn_mem_ctrl #(.READ_LAT(L), .DEPTH(4096)) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .wr_req(wr_req),
      .address(address), .to_memory(to_memory),
      .from_memory(from_memory), .mem_ready(mem_ready),
      .ld_en(ld_en), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_done(ld_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h (cyc %0d)",
                  nm, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mem_ready) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_mem_ready actual=1 required=0 (cyc %0d)",
                     cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("ready_cycle", cyc, e.cyc);
            chk("from_memory", {16'h0, from_memory}, {16'h0, e.data});
         end
      end
      if (ld_done) begin
         ld_done_cnt++;
         chk("ld_done_cycle", cyc, ld_done_exp);
      end
   end

   task automatic cpu_write(input logic [11:0] a, input logic [15:0] d,
                            input logic with_rd);
      address   = a;
      to_memory = d;
      wr_req    = 1'b1;
      rd_req    = with_rd;
      q.push_back('{exp_fm, cyc + 1});
      @(negedge clk);
      wr_req = 1'b0;
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [11:0] a, input logic [15:0] e);
      address = a;
      rd_req  = 1'b1;
      q.push_back('{e, cyc + L + 2});
      exp_fm = e;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (L + 2) @(negedge clk);
   endtask

   task automatic ld_send(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_data  = b;
      @(negedge clk);
   endtask

   task automatic ld_enter();
      ld_en = 1'b1;
      @(negedge clk);
      chk("ld_ready_in_load", {31'h0, ld_ready}, 32'h1);
   endtask

   task automatic ld_exit();
      ld_valid = 1'b0;
      ld_en    = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      @(negedge clk);
      chk("ld_ready_after_exit", {31'h0, ld_ready}, 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      repeat (2) @(negedge clk);
      chk("rst_from_memory", {16'h0, from_memory}, 32'h0);
      chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
      chk("rst_ld_done", {31'h0, ld_done}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      cpu_write(12'h010, 16'hBEEF, 1'b0);
      cpu_read(12'h010, 16'hBEEF);
      cpu_write(12'h010, 16'h1111, 1'b0);
      cpu_read(12'h010, 16'h1111);

      cpu_write(12'h020, 16'h1234, 1'b1);
      cpu_read(12'h020, 16'h1234);

      ld_enter();
      ld_send(8'h34);
      ld_send(8'h12);
      ld_send(8'hCD);
      ld_send(8'hAB);
      ld_exit();
      cpu_read(12'h000, 16'h1234);
      cpu_read(12'h001, 16'hABCD);

      address = 12'h001;
      rd_req  = 1'b1;
      q.push_back('{16'hABCD, cyc + L + 2});
      exp_fm = 16'hABCD;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      rd_req    = 1'b1;
      wr_req    = 1'b1;
      to_memory = 16'hDEAD;
      @(negedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
      repeat (L) @(negedge clk);
      cpu_read(12'h001, 16'hABCD);

      cpu_write(12'h030, 16'h5555, 1'b0);
      address = 12'h030;
      rd_req  = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midread_rst_from_memory", {16'h0, from_memory}, 32'h0);
      chk("midread_rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exp_fm = 16'h0000;
      repeat (4) @(negedge clk);
      cpu_read(12'h030, 16'h5555);

      ld_enter();
      address   = 12'h002;
      to_memory = 16'hDEAD;
      rd_req    = 1'b1;
      wr_req    = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         w = 16'(i * 7 + 3);
         if (i == 4095) ld_done_exp = cyc + 2;
         ld_send(w[7:0]);
         ld_send(w[15:8]);
      end
      ld_send(8'hEF);
      ld_send(8'hBE);
      ld_exit();
      chk("ld_done_count", ld_done_cnt, 1);
      cpu_read(12'h000, 16'hBEEF);
      cpu_read(12'h001, 16'h000A);
      cpu_read(12'h002, 16'h0011);
      cpu_read(12'hFFF, 16'h6FFC);

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      chk("ld_done_final", ld_done_cnt, 1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
